// File: rtl/lc_cfg_pkg.sv
// Shared definitions for the logic-cell configuration loader:
// frame opcodes, loader states, word widths and the frame parity helper.
package lc_cfg_pkg;

   localparam int LUT_W     = 16;
   localparam int CTRL_W    = 4;
   localparam int PAYLOAD_W = LUT_W + CTRL_W;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      HDR,
      PAYLOAD,
      COMMIT,
      READOUT,
      CLEAR
   } state_e;

   // Even-parity bit over a header (given as its XOR) followed by a data word.
   function automatic logic calc_parity(input logic hdr_par, input logic [PAYLOAD_W-1:0] data);
      return hdr_par ^ (^data);
   endfunction

endpackage

// File: rtl/lc_cfg_shifter.sv
// MSB-first shift register with bit counter and running parity; used both to
// deserialise incoming frames and to serialise readback words.
module lc_cfg_shifter #(
   parameter int W     = 21,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [W-1:0]     load_data,
   input  logic             restart,
   input  logic             shift,
   input  logic             shift_in,
   output logic [W-1:0]     data,
   output logic [CNT_W-1:0] count,
   output logic             parity
);

   // restart empties the word for the next field but keeps the frame parity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data   <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (clear) begin
         data   <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (load) begin
         data   <= load_data;
         count  <= '0;
         parity <= 1'b0;
      end else if (restart) begin
         data   <= '0;
         count  <= '0;
         parity <= parity ^ shift_in;
      end else if (shift) begin
         data   <= {data[W-2:0], shift_in};
         count  <= count + 1'b1;
         parity <= parity ^ shift_in;
      end
   end

endmodule

// File: rtl/lc_config_loader.sv
// Serial configuration port for the logic-cell array: decodes framed bitstreams,
// holds every cell's LUT and control word, and serves serial readback.
module lc_config_loader
   import lc_cfg_pkg::*;
#(
   parameter int NUM_CELLS = 16,
   parameter int ADDR_W    = 4
) (
   input  logic                          QCK,
   input  logic                          QRT_N,
   input  logic                          SDI,
   input  logic                          SDI_VALID,
   output logic                          SDI_READY,
   input  logic                          ABORT,
   input  logic                          ERR_CLR,
   output logic                          SDO,
   output logic                          SDO_VALID,
   output logic                          BUSY,
   output logic                          ERR,
   output logic                          CFG_UPD,
   output logic [NUM_CELLS*LUT_W-1:0]    LFRAG_BITS,
   output logic [NUM_CELLS*CTRL_W-1:0]   CTRL_BITS
);

   localparam int HDR_W = 2 + ADDR_W;
   localparam int SH_W  = PAYLOAD_W + 1;
   localparam int CNT_W = $clog2(SH_W + 1);
   localparam logic [ADDR_W:0]   CELL_LIM  = (ADDR_W+1)'(NUM_CELLS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

   state_e            state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] clr_idx;
   logic              err_q;
   logic [LUT_W-1:0]  lut_mem  [NUM_CELLS];
   logic [CTRL_W-1:0] ctrl_mem [NUM_CELLS];

   logic [SH_W-1:0]   sh_data;
   logic [SH_W-1:0]   sh_load_data;
   logic [CNT_W-1:0]  sh_count;
   logic              sh_parity, sh_clear, sh_load, sh_restart, sh_shift;

   logic              accept, hdr_last, pay_last, ro_last;
   logic              rd_ok, commit_ok, clr_done, err_set;
   logic [HDR_W-1:0]  hdr_word;
   op_e               hdr_op;
   logic [ADDR_W-1:0] hdr_addr;
   logic [LUT_W-1:0]  rd_lut;
   logic [CTRL_W-1:0] rd_ctrl;

   assign SDI_READY = (state == HDR) || (state == PAYLOAD);
   assign accept    = SDI_VALID && SDI_READY;

   // The header is decoded in the cycle its last bit arrives, before it is shifted in.
   assign hdr_word  = {sh_data[HDR_W-2:0], SDI};
   assign hdr_op    = op_e'(hdr_word[HDR_W-1 -: 2]);
   assign hdr_addr  = hdr_word[ADDR_W-1:0];
   assign hdr_last  = accept && (state == HDR) && (sh_count == CNT_W'(HDR_W - 1));
   assign pay_last  = accept && (state == PAYLOAD) && (sh_count == CNT_W'(PAYLOAD_W));
   assign ro_last   = (state == READOUT) && (sh_count == CNT_W'(PAYLOAD_W));
   assign rd_ok     = {1'b0, hdr_addr} < CELL_LIM;
   assign commit_ok = !ABORT && (state == COMMIT) && !sh_parity && ({1'b0, addr_q} < CELL_LIM);
   assign clr_done  = !ABORT && (state == CLEAR) && (clr_idx == LAST_CELL);
   assign err_set   = !ABORT && ((hdr_last && hdr_op == OP_READ && !rd_ok) ||
                                 (state == COMMIT && !commit_ok));

   always_comb begin
      rd_lut  = '0;
      rd_ctrl = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (hdr_addr == ADDR_W'(i)) begin
            rd_lut  = lut_mem[i];
            rd_ctrl = ctrl_mem[i];
         end
      end
   end

   always_comb begin
      sh_clear     = ABORT || (state == COMMIT) || (state == CLEAR) || ro_last ||
                     (hdr_last && (hdr_op == OP_NOP || hdr_op == OP_CLEAR ||
                                   (hdr_op == OP_READ && !rd_ok)));
      sh_load      = hdr_last && (hdr_op == OP_READ) && rd_ok;
      sh_restart   = hdr_last && (hdr_op == OP_WRITE);
      sh_shift     = (accept && !hdr_last) || (state == READOUT);
      sh_load_data = {rd_lut, rd_ctrl, calc_parity(sh_parity ^ SDI, {rd_lut, rd_ctrl})};
   end

   lc_cfg_shifter #(
      .W     (SH_W),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk       (QCK),
      .rst_n     (QRT_N),
      .clear     (sh_clear),
      .load      (sh_load),
      .load_data (sh_load_data),
      .restart   (sh_restart),
      .shift     (sh_shift),
      .shift_in  (SDI),
      .data      (sh_data),
      .count     (sh_count),
      .parity    (sh_parity)
   );

   // Cell storage only changes in COMMIT or CLEAR, so the array never sees a half frame.
   always_ff @(posedge QCK or negedge QRT_N) begin
      if (!QRT_N) begin
         state   <= HDR;
         addr_q  <= '0;
         clr_idx <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_CELLS; i++) begin
            lut_mem[i]  <= '0;
            ctrl_mem[i] <= '0;
         end
      end else begin
         err_q <= err_set | (err_q & ~ERR_CLR);
         if (ABORT) begin
            state   <= HDR;
            clr_idx <= '0;
         end else begin
            case (state)
               HDR: begin
                  if (hdr_last) begin
                     addr_q  <= hdr_addr;
                     clr_idx <= '0;
                     case (hdr_op)
                        OP_WRITE: state <= PAYLOAD;
                        OP_READ:  state <= rd_ok ? READOUT : HDR;
                        OP_CLEAR: state <= CLEAR;
                        default:  state <= HDR;
                     endcase
                  end
               end
               PAYLOAD: begin
                  if (pay_last) state <= COMMIT;
               end
               COMMIT: begin
                  for (int i = 0; i < NUM_CELLS; i++) begin
                     if (commit_ok && addr_q == ADDR_W'(i)) begin
                        lut_mem[i]  <= sh_data[SH_W-1 -: LUT_W];
                        ctrl_mem[i] <= sh_data[CTRL_W:1];
                     end
                  end
                  state <= HDR;
               end
               READOUT: begin
                  if (ro_last) state <= HDR;
               end
               CLEAR: begin
                  for (int i = 0; i < NUM_CELLS; i++) begin
                     if (clr_idx == ADDR_W'(i)) begin
                        lut_mem[i]  <= '0;
                        ctrl_mem[i] <= '0;
                     end
                  end
                  if (clr_idx == LAST_CELL) state <= HDR;
                  else                      clr_idx <= clr_idx + 1'b1;
               end
               default: state <= HDR;
            endcase
         end
      end
   end

   assign SDO_VALID = (state == READOUT);
   assign SDO       = SDO_VALID & sh_data[SH_W-1];
   assign BUSY      = (state != HDR) || (sh_count != '0);
   assign ERR       = err_q;
   assign CFG_UPD   = commit_ok || clr_done;

   for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell_out
      assign LFRAG_BITS[g*LUT_W +: LUT_W]  = lut_mem[g];
      assign CTRL_BITS[g*CTRL_W +: CTRL_W] = ctrl_mem[g];
   end

endmodule

// File: tb/tb_lc_config_loader.sv
// Randomised scoreboard bench for lc_config_loader: frames are generated from a
// cell-array model, and a monitor checks every update pulse and readback bit.
module tb_lc_config_loader;

   localparam int NC = 12;
   localparam int AW = 4;
   localparam logic [1:0] T_NOP   = 2'b00;
   localparam logic [1:0] T_WRITE = 2'b01;
   localparam logic [1:0] T_READ  = 2'b10;
   localparam logic [1:0] T_CLEAR = 2'b11;

   logic QCK = 1'b0;
   logic QRT_N = 1'b0;
   logic SDI = 1'b0;
   logic SDI_VALID = 1'b0;
   logic ABORT = 1'b0;
   logic ERR_CLR = 1'b0;
   logic SDI_READY, SDO, SDO_VALID, BUSY, ERR, CFG_UPD;
   logic [NC*16-1:0] LFRAG_BITS;
   logic [NC*4-1:0]  CTRL_BITS;

   always #5 QCK = ~QCK;

   lc_config_loader #(
      .NUM_CELLS (NC),
      .ADDR_W    (AW)
   ) dut (
      .QCK        (QCK),
      .QRT_N      (QRT_N),
      .SDI        (SDI),
      .SDI_VALID  (SDI_VALID),
      .SDI_READY  (SDI_READY),
      .ABORT      (ABORT),
      .ERR_CLR    (ERR_CLR),
      .SDO        (SDO),
      .SDO_VALID  (SDO_VALID),
      .BUSY       (BUSY),
      .ERR        (ERR),
      .CFG_UPD    (CFG_UPD),
      .LFRAG_BITS (LFRAG_BITS),
      .CTRL_BITS  (CTRL_BITS)
   );

   typedef struct {
      logic [NC*16-1:0] l;
      logic [NC*4-1:0]  c;
   } img_t;

   int   checks = 0;
   int   errors = 0;
   logic [15:0] m_lut  [NC];
   logic [3:0]  m_ctrl [NC];
   logic        m_err;
   img_t        exp_upd_q [$];
   logic        exp_sdo_q [$];

   function automatic img_t modelImage();
      img_t r;
      for (int i = 0; i < NC; i++) begin
         r.l[i*16 +: 16] = m_lut[i];
         r.c[i*4 +: 4]   = m_ctrl[i];
      end
      return r;
   endfunction

   task automatic compare(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT signals an update or a readback bit.
   initial begin : monitor
      img_t pend;
      bit   have;
      have = 1'b0;
      forever begin
         @(negedge QCK);
         if (have) begin
            compare("stored_lut", 256'(LFRAG_BITS), 256'(pend.l));
            compare("stored_ctrl", 256'(CTRL_BITS), 256'(pend.c));
            have = 1'b0;
         end
         if (QRT_N && CFG_UPD) begin
            if (exp_upd_q.size() == 0) compare("unexpected_cfg_upd", 256'(CFG_UPD), 256'(0));
            else begin
               pend = exp_upd_q.pop_front();
               have = 1'b1;
            end
         end
         if (SDO_VALID) begin
            if (exp_sdo_q.size() == 0) compare("unexpected_sdo_valid", 256'(SDO_VALID), 256'(0));
            else begin
               compare("sdo_bit", 256'(SDO), 256'(exp_sdo_q.pop_front()));
               compare("sdi_ready_in_readout", 256'(SDI_READY), 256'(0));
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] timeout");
   end

   // Called just after a negedge; returns one negedge after the bit was taken.
   task automatic driveBit(input logic b);
      int guard;
      guard = 0;
      if ($urandom_range(0, 3) == 0) begin
         SDI_VALID = 1'b0;
         @(negedge QCK);
      end
      while (!SDI_READY && guard < 200) begin
         SDI_VALID = 1'b0;
         @(negedge QCK);
         guard++;
      end
      if (guard >= 200) compare("sdi_ready_timeout", 256'(SDI_READY), 256'(1));
      SDI       = b;
      SDI_VALID = 1'b1;
      @(negedge QCK);
      SDI_VALID = 1'b0;
   endtask

   task automatic checkOutput(input int exp_tail);
      int   tail;
      img_t img;
      tail = 0;
      while (BUSY && tail < 200) begin
         tail++;
         @(negedge QCK);
      end
      compare("busy_cycles", 256'(tail), 256'(exp_tail));
      @(negedge QCK);
      img = modelImage();
      compare("err_flag", 256'(ERR), 256'(m_err));
      compare("idle_lut", 256'(LFRAG_BITS), 256'(img.l));
      compare("idle_ctrl", 256'(CTRL_BITS), 256'(img.c));
      compare("idle_ready", 256'(SDI_READY), 256'(1));
      compare("upd_drained", 256'(exp_upd_q.size()), 256'(0));
      compare("sdo_drained", 256'(exp_sdo_q.size()), 256'(0));
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] addr,
                                input logic [15:0] lut, input logic [3:0] ctrl, input bit bad_par);
      logic bits [$];
      int   tail;
      bits.push_back(op[1]);
      bits.push_back(op[0]);
      for (int i = AW-1; i >= 0; i--) bits.push_back(addr[i]);
      tail = 0;
      case (op)
         T_WRITE: begin
            for (int i = 15; i >= 0; i--) bits.push_back(lut[i]);
            for (int i = 3; i >= 0; i--)  bits.push_back(ctrl[i]);
            bits.push_back((^{op, addr, lut, ctrl}) ^ bad_par);
            if (!bad_par && int'(addr) < NC) begin
               m_lut[addr]  = lut;
               m_ctrl[addr] = ctrl;
               exp_upd_q.push_back(modelImage());
            end else m_err = 1'b1;
            tail = 1;
         end
         T_READ: begin
            if (int'(addr) < NC) begin
               for (int i = 15; i >= 0; i--) exp_sdo_q.push_back(m_lut[addr][i]);
               for (int i = 3; i >= 0; i--)  exp_sdo_q.push_back(m_ctrl[addr][i]);
               exp_sdo_q.push_back(^{op, addr, m_lut[addr], m_ctrl[addr]});
               tail = 21;
            end else m_err = 1'b1;
         end
         T_CLEAR: begin
            for (int i = 0; i < NC; i++) begin
               m_lut[i]  = '0;
               m_ctrl[i] = '0;
            end
            exp_upd_q.push_back(modelImage());
            tail = NC;
         end
         default: tail = 0;
      endcase
      foreach (bits[i]) driveBit(bits[i]);
      checkOutput(tail);
   endtask

   // Sends the first nbits of a WRITE frame, then aborts it.
   task automatic abortFrame(input logic [3:0] addr, input int nbits);
      logic bits [$];
      bits.push_back(T_WRITE[1]);
      bits.push_back(T_WRITE[0]);
      for (int i = AW-1; i >= 0; i--) bits.push_back(addr[i]);
      for (int i = 0; i < 21; i++) bits.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < nbits; i++) driveBit(bits[i]);
      ABORT = 1'b1;
      @(negedge QCK);
      ABORT = 1'b0;
      compare("abort_busy", 256'(BUSY), 256'(0));
      compare("abort_ready", 256'(SDI_READY), 256'(1));
      checkOutput(0);
   endtask

   task automatic clearErr();
      ERR_CLR = 1'b1;
      @(negedge QCK);
      ERR_CLR = 1'b0;
      m_err   = 1'b0;
      compare("err_cleared", 256'(ERR), 256'(0));
   endtask

   initial begin : stimulus
      int r;
      for (int i = 0; i < NC; i++) begin
         m_lut[i]  = '0;
         m_ctrl[i] = '0;
      end
      m_err = 1'b0;

      repeat (3) @(negedge QCK);
      compare("rst_lut", 256'(LFRAG_BITS), 256'(0));
      compare("rst_ctrl", 256'(CTRL_BITS), 256'(0));
      compare("rst_busy", 256'(BUSY), 256'(0));
      compare("rst_err", 256'(ERR), 256'(0));
      compare("rst_sdo_valid", 256'(SDO_VALID), 256'(0));
      compare("rst_cfg_upd", 256'(CFG_UPD), 256'(0));
      QRT_N = 1'b1;
      @(negedge QCK);
      compare("rst_ready", 256'(SDI_READY), 256'(1));

      $display("[TB] directed frames");
      applyStimulus(T_WRITE, 4'd3, 16'h8000, 4'b0001, 1'b0);
      compare("cell3_lut", 256'(LFRAG_BITS[63:48]), 256'(16'h8000));
      compare("cell3_ctrl", 256'(CTRL_BITS[15:12]), 256'(4'b0001));
      applyStimulus(T_WRITE, 4'd3, 16'h8000, 4'b0001, 1'b1);
      clearErr();
      applyStimulus(T_READ, 4'd3, 16'h0, 4'h0, 1'b0);
      applyStimulus(T_WRITE, 4'd0, 16'hFFFF, 4'hF, 1'b0);
      applyStimulus(T_WRITE, 4'd5, 16'hFFFF, 4'hA, 1'b0);
      applyStimulus(T_CLEAR, 4'd0, 16'h0, 4'h0, 1'b0);
      abortFrame(4'd7, 16);
      applyStimulus(T_WRITE, 4'd7, 16'h1234, 4'b0110, 1'b0);
      applyStimulus(T_READ, 4'd7, 16'h0, 4'h0, 1'b0);
      applyStimulus(T_WRITE, 4'd13, 16'hBEEF, 4'h3, 1'b0);
      applyStimulus(T_READ, 4'd13, 16'h0, 4'h0, 1'b0);
      clearErr();
      applyStimulus(T_WRITE, 4'd11, 16'hA5A5, 4'h9, 1'b0);
      applyStimulus(T_READ, 4'd11, 16'h0, 4'h0, 1'b0);

      $display("[TB] random frames");
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r == 9) abortFrame(4'($urandom_range(0, 15)), $urandom_range(1, 26));
         else if (r == 0) applyStimulus(T_NOP, 4'($urandom_range(0, 15)), 16'h0, 4'h0, 1'b0);
         else if (r <= 4) applyStimulus(T_WRITE, 4'($urandom_range(0, 15)), 16'($urandom),
                                        4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
         else if (r <= 7) applyStimulus(T_READ, 4'($urandom_range(0, 15)), 16'h0, 4'h0, 1'b0);
         else applyStimulus(T_CLEAR, 4'd0, 16'h0, 4'h0, 1'b0);
         if ($urandom_range(0, 3) == 0) clearErr();
      end

      repeat (5) @(negedge QCK);
      compare("final_upd_drained", 256'(exp_upd_q.size()), 256'(0));
      compare("final_sdo_drained", 256'(exp_sdo_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc_config_loader.md
Name: lc_config_loader

Overview:
- Serial configuration port for an array of ONE_LOGIC_CELL-style logic cells.
- Receives framed bitstreams and deserialises them into per-cell 16-bit LUT words plus 4 flip-flop control bits (CDS, QSTS, QRTS, QEN_FORCE).
- Holds the configuration for all cells and drives it onto the cell array.
- Provides serial readback: it is the writer for the cell configuration bits and the reader for readback.

Parameters:
- NUM_CELLS, 16, number of logic cells configured (1..16).
- ADDR_W, 4, cell address width; NUM_CELLS must be ≤ 2**ADDR_W.
- LUT_W, 16, LUT config bits per cell; fixed at 16.
- CTRL_W, 4, control bits per cell, order MSB→LSB: CDS, QSTS, QRTS, QEN_FORCE.

Ports:
- QCK  in  1  clock; all logic on rising edge.
- QRT_N  in  1  reset, asynchronous, active-low.
- SDI  in  1  serial config data, MSB first.
- SDI_VALID  in  1  SDI bit valid.
- SDI_READY  out  1  loader accepts a bit this cycle.
- ABORT  in  1  discard the current frame and return to the header state.
- ERR_CLR  in  1  clear the sticky ERR flag.
- SDO  out  1  readback data.
- SDO_VALID  out  1  SDO bit valid.
- BUSY  out  1  high in any state except HDR, or while a partial header is held.
- ERR  out  1  sticky error flag.
- CFG_UPD  out  1  one-cycle pulse when a cell word is committed.
- LFRAG_BITS  out  NUM_CELLS*LUT_W  flattened LUT words; cell i occupies [i*16 +: 16].
- CTRL_BITS  out  NUM_CELLS*CTRL_W  flattened control bits; cell i occupies [i*4 +: 4].

Behaviour:
- Reset (QRT_N=0, asynchronous): state=HDR; all storage 0; LFRAG_BITS=0, CTRL_BITS=0; SDO=0, SDO_VALID=0, ERR=0, CFG_UPD=0, BUSY=0; SDI_READY=1 after deassertion.
- Bit transfer: a bit is accepted when SDI_VALID && SDI_READY. SDI_READY=1 only in HDR and PAYLOAD.
- Header: HDR_W = 2+ADDR_W bits, MSB first: op[1:0], then addr.
  - op 00 = NOP, 01 = WRITE, 10 = READ, 11 = CLEAR_ALL.
- HDR state: counts header bits. On the last header bit:
  - NOP → HDR.
  - WRITE → PAYLOAD.
  - READ → READOUT if addr < NUM_CELLS; else set ERR and go to HDR.
  - CLEAR_ALL → CLEAR.
- PAYLOAD state: accepts 16 LUT bits, then 4 ctrl bits, then 1 parity bit (21 bits).
  - Parity is even over header + 20 data bits + parity bit.
  - On the last bit go to COMMIT.
- COMMIT state (1 cycle, SDI_READY=0):
  - If parity is good and addr < NUM_CELLS: write the cell word; LFRAG_BITS and CTRL_BITS show the new value on the next cycle; CFG_UPD=1 for exactly this cycle.
  - Otherwise set ERR and leave storage unchanged.
  - Next state: HDR.
- READOUT state: 21 consecutive cycles with SDO_VALID=1.
  - Order: 16 LUT bits MSB first, 4 ctrl bits, then an even parity bit computed over the READ header + 20 data bits.
  - Readback data is snapshotted on entry to READOUT.
  - Next state: HDR.
- CLEAR state: zeroes one cell per cycle, cell 0 to NUM_CELLS-1 (NUM_CELLS cycles).
  - CFG_UPD pulses once on the final cycle.
  - Next state: HDR.
- ABORT: synchronous; takes priority over all other transitions.
  - Next cycle state=HDR and bit counters=0.
  - No commit; a READOUT in progress stops (SDO_VALID=0 next cycle).
  - A CLEAR in progress stops with cells already cleared left at zero.
- ERR: sticky. ERR_CLR clears it; if a new error occurs in the same cycle as ERR_CLR, the set wins.
- SDI_VALID low mid-frame: the loader waits indefinitely; there is no timeout.
- Cell outputs never glitch mid-frame; storage changes only in COMMIT or CLEAR.

Decomposition:
- Package lc_cfg_pkg holds:
  - op encodings: OP_NOP, OP_WRITE, OP_READ, OP_CLEAR.
  - state enum: HDR, PAYLOAD, COMMIT, READOUT, CLEAR.
  - LUT_W, CTRL_W, PAYLOAD_W = 20.
  - a function computing the parity bit.
- One sub-module, lc_cfg_shifter: shift register with bit counter and running parity, reused for both deserialise and serialise.

Test Plan:
- Reset, then WRITE addr 3, LUT 0x8000, ctrl 0001, parity 1 → one CFG_UPD pulse; LFRAG_BITS[63:48]=0x8000; CTRL_BITS[15:12]=0001; all other cells 0; ERR=0.
- Same frame with parity bit 0 → ERR=1, no CFG_UPD, storage unchanged; ERR_CLR → ERR=0.
- READ addr 3 after the first test → 21 SDO_VALID cycles carrying 1000…0000, then 0001, then the parity bit; SDI_READY=0 throughout.
- WRITE to cells 0 and 5 with 0xFFFF, then CLEAR_ALL → BUSY for 16 cycles, then all LFRAG_BITS=0 and one CFG_UPD pulse.
- ABORT asserted after 10 payload bits of a WRITE → state HDR, no update; a following valid WRITE commits correctly.
- With NUM_CELLS=12, WRITE and READ to addr 13 → ERR=1, no CFG_UPD, no SDO_VALID.
